shared_arith_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multi-cycle arithmetic unit (multiplier or divider) between up to eight requesters, such as step-size control and integration datapaths. It sits between those requesters' start/done handshakes and the single unit's start/done interface. It latches the operands of the winning requester, issues one unit operation, captures the result and returns it with a one-cycle done pulse to that requester only.

---
 rtl/shared_arith_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_shared_arith_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_arith_arbiter.sv
// Round-robin arbiter sharing one multi-cycle arithmetic unit between NUM_REQ requesters.
// Optional WAIT watchdog with error reporting is enabled by defining ARB_TIMEOUT_EN.
module shared_arith_arbiter #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_a,
    input  logic [NUM_REQ*WORD_SIZE-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_op,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         req_error,
    output logic [WORD_SIZE-1:0]         result,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic                         unit_start,
    output logic                         unit_op,
    output logic [WORD_SIZE-1:0]         unit_a,
    output logic [WORD_SIZE-1:0]         unit_b,
    input  logic                         unit_done,
    input  logic [WORD_SIZE-1:0]         unit_result
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        ptr_q;
    logic [PtrW-1:0]        gidx_q;
    logic [PtrW-1:0]        ptr_next;
    logic [PtrW-1:0]        sel_idx;
    logic [PtrW-1:0]        cand_idx;
    int                     cand;
    logic                   sel_valid;
    logic [WORD_SIZE-1:0]   sel_a, sel_b;
    logic                   sel_op;
    logic [WORD_SIZE-1:0]   a_q, b_q, result_q;
    logic                   op_q;
    logic                   timeout_hit;
    logic                   err_flag;

    // First requesting index at or above ptr_q, wrapping modulo NUM_REQ.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 0; off < int'(NUM_REQ); off++) begin
            cand     = (int'(ptr_q) + off) % int'(NUM_REQ);
            cand_idx = PtrW'(cand);
            if (!sel_valid && req[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (sel_idx == PtrW'(i)) begin
                sel_a  = req_a[i*WORD_SIZE +: WORD_SIZE];
                sel_b  = req_b[i*WORD_SIZE +: WORD_SIZE];
                sel_op = req_op[i];
            end
        end
    end

    assign ptr_next = (gidx_q == PtrW'(NUM_REQ - 1)) ? '0 : gidx_q + PtrW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    // cnt_q holds the number of WAIT cycles already elapsed before the current one.
    assign timeout_hit = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign err_flag    = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == StIssue) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + CntW'(1);
                if (unit_done) begin
                    err_q <= 1'b0;
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign err_flag           = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sel_valid) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (unit_done || timeout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grant bookkeeping, operand latch and result capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q    <= '0;
            gidx_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            result_q <= '0;
        end else begin
            if (state_q == StIdle && sel_valid) begin
                gidx_q <= sel_idx;
                a_q    <= sel_a;
                b_q    <= sel_b;
                op_q   <= sel_op;
            end
            if (state_q == StWait) begin
                if (unit_done) begin
                    result_q <= unit_result;
                end else if (timeout_hit) begin
                    result_q <= '0;
                end
            end
            if (state_q == StResp) begin
                ptr_q <= ptr_next;
            end
        end
    end

    // Outputs
    always_comb begin
        grant      = '0;
        req_done   = '0;
        busy       = (state_q != StIdle);
        unit_start = (state_q == StIssue);
        req_error  = 1'b0;
        if (state_q != StIdle) begin
            grant[gidx_q] = 1'b1;
        end
        if (state_q == StResp) begin
            req_done[gidx_q] = 1'b1;
            req_error        = err_flag;
        end
    end

    assign result  = result_q;
    assign unit_a  = a_q;
    assign unit_b  = b_q;
    assign unit_op = op_q;

endmodule

// File: tb/tb_shared_arith_arbiter.sv
// Directed self-checking bench for shared_arith_arbiter; the unit's done/result are driven by hand.
// The timeout scenario is compiled only when ARB_TIMEOUT_EN is defined.
module tb_shared_arith_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_op;
    logic [N-1:0]     req_done;
    logic             req_error;
    logic [W-1:0]     result;
    logic [N-1:0]     grant;
    logic             busy, unit_start, unit_op;
    logic [W-1:0]     unit_a, unit_b;
    logic             unit_done;
    logic [W-1:0]     unit_result;

    int checks = 0;
    int failures = 0;

    shared_arith_arbiter #(
        .WORD_SIZE(W),
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .req_done(req_done),
        .req_error(req_error),
        .result(result),
        .grant(grant),
        .busy(busy),
        .unit_start(unit_start),
        .unit_op(unit_op),
        .unit_a(unit_a),
        .unit_b(unit_b),
        .unit_done(unit_done),
        .unit_result(unit_result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_a = '0; req_b = '0; req_op = '0;
        unit_done = 1'b0; unit_result = '0;
        tick(); tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_done !== 4'b0000 || req_error !== 1'b0) begin failures++; $display("FAIL reset_done got=%b/%b exp=0000/0", req_done, req_error); end
        checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
        checks++; if (unit_start !== 1'b0 || unit_op !== 1'b0) begin failures++; $display("FAIL reset_unit_ctl got=%b%b exp=00", unit_start, unit_op); end
        checks++; if (unit_a !== 32'd0 || unit_b !== 32'd0) begin failures++; $display("FAIL reset_operands got=%0d,%0d exp=0,0", unit_a, unit_b); end
        rst = 1'b1;
    endtask

    task automatic test_single();
        req_a[1*W +: W] = 32'd6; req_b[1*W +: W] = 32'd7; req_op[1] = 1'b0;
        req = 4'b0010;
        tick(); // edge n samples req
        checks++; if (grant !== 4'b0010 || busy !== 1'b1) begin failures++; $display("FAIL single_grant got=%b/%b exp=0010/1", grant, busy); end
        checks++; if (unit_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", unit_start); end
        checks++; if (unit_a !== 32'd6 || unit_b !== 32'd7 || unit_op !== 1'b0) begin failures++; $display("FAIL single_operands got=%0d,%0d,%b exp=6,7,0", unit_a, unit_b, unit_op); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            if (c == 4) begin unit_done = 1'b1; unit_result = 32'd42; end
            checks++; if (unit_start !== 1'b0 || req_done !== 4'b0000) begin failures++; $display("FAIL single_quiet cycle=%0d got start=%b done=%b exp=0/0000", c, unit_start, req_done); end
        end
        tick(); // cycle n+5
        unit_done = 1'b0; unit_result = '0;
        checks++; if (req_done !== 4'b0010) begin failures++; $display("FAIL single_done got=%b exp=0010", req_done); end
        checks++; if (result !== 32'd42 || req_error !== 1'b0) begin failures++; $display("FAIL single_result got=%0d/%b exp=42/0", result, req_error); end
        req = 4'b0000;
        tick();
        checks++; if (busy !== 1'b0 || req_done !== 4'b0000 || result !== 32'd42) begin failures++; $display("FAIL single_after got=%b/%b/%0d exp=0/0000/42", busy, req_done, result); end
    endtask

    task automatic test_round_robin();
        int exp_idx;
        int served [N];
        rst = 1'b0; tick(); rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            served[i] = 0;
            req_a[i*W +: W] = 32'(10 + i);
            req_b[i*W +: W] = 32'(20 + i);
            req_op[i] = i[0];
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % N;
            tick(); // ISSUE
            checks++; if (grant !== 4'(1 << exp_idx)) begin failures++; $display("FAIL rr_grant op=%0d got=%b exp=%b", k, grant, 4'(1 << exp_idx)); end
            checks++; if (unit_a !== 32'(10 + exp_idx) || unit_op !== exp_idx[0]) begin failures++; $display("FAIL rr_operand op=%0d got=%0d,%b exp=%0d,%b", k, unit_a, unit_op, 10 + exp_idx, exp_idx[0]); end
            tick(); // WAIT
            unit_done = 1'b1; unit_result = 32'(100 + k);
            tick(); // RESP
            unit_done = 1'b0;
            for (int i = 0; i < N; i++) served[i] += int'(req_done[i]);
            checks++; if (req_done !== 4'(1 << exp_idx) || result !== 32'(100 + k)) begin failures++; $display("FAIL rr_done op=%0d got=%b,%0d exp=%b,%0d", k, req_done, result, 4'(1 << exp_idx), 100 + k); end
            if (k == 4) req = 4'b0000;
            tick(); // IDLE
        end
        for (int i = 0; i < N; i++) begin
            checks++; if (served[i] !== ((i == 0) ? 2 : 1)) begin failures++; $display("FAIL rr_fairness req=%0d got=%0d exp=%0d", i, served[i], (i == 0) ? 2 : 1); end
        end
    endtask

    task automatic test_early_drop();
        req_a[2*W +: W] = 32'd20; req_b[2*W +: W] = 32'd5; req_op[2] = 1'b1;
        req = 4'b0100;
        tick(); // ISSUE
        checks++; if (grant !== 4'b0100 || unit_op !== 1'b1) begin failures++; $display("FAIL drop_grant got=%b,%b exp=0100,1", grant, unit_op); end
        req = 4'b0000;
        req_a[2*W +: W] = 32'd999; req_b[2*W +: W] = 32'd888;
        tick(); // WAIT
        checks++; if (unit_a !== 32'd20 || unit_b !== 32'd5 || grant !== 4'b0100) begin failures++; $display("FAIL drop_hold got=%0d,%0d,%b exp=20,5,0100", unit_a, unit_b, grant); end
        unit_done = 1'b1; unit_result = 32'd4;
        tick(); // RESP
        unit_done = 1'b0;
        checks++; if (req_done !== 4'b0100 || result !== 32'd4) begin failures++; $display("FAIL drop_done got=%b,%0d exp=0100,4", req_done, result); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drop_idle got=%b exp=0", busy); end
    endtask

    task automatic test_spurious_done();
        unit_done = 1'b1; unit_result = 32'd55;
        tick(); // still IDLE
        checks++; if (busy !== 1'b0 || req_done !== 4'b0000 || result !== 32'd4) begin failures++; $display("FAIL spur_idle got=%b,%b,%0d exp=0,0000,4", busy, req_done, result); end
        unit_done = 1'b0;
        req_a[0 +: W] = 32'd3; req_b[0 +: W] = 32'd9; req_op[0] = 1'b0;
        req = 4'b0001;
        tick(); // ISSUE
        unit_done = 1'b1; unit_result = 32'd77;
        tick(); // WAIT, done in ISSUE was ignored
        unit_done = 1'b0;
        checks++; if (busy !== 1'b1 || unit_start !== 1'b0 || req_done !== 4'b0000 || result !== 32'd4) begin failures++; $display("FAIL spur_issue got=%b,%b,%b,%0d exp=1,0,0000,4", busy, unit_start, req_done, result); end
        tick(); // still WAIT
        checks++; if (busy !== 1'b1 || req_done !== 4'b0000) begin failures++; $display("FAIL spur_wait got=%b,%b exp=1,0000", busy, req_done); end
        unit_done = 1'b1; unit_result = 32'd27;
        tick(); // RESP
        unit_done = 1'b0; req = 4'b0000;
        checks++; if (req_done !== 4'b0001 || result !== 32'd27) begin failures++; $display("FAIL spur_done got=%b,%0d exp=0001,27", req_done, result); end
        tick();
    endtask

    task automatic test_reset_mid_op();
        req_a[3*W +: W] = 32'd11; req_b[3*W +: W] = 32'd12; req_op[3] = 1'b1;
        req = 4'b1000;
        tick(); // ISSUE
        tick(); // WAIT
        rst = 1'b0;
        tick();
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || unit_start !== 1'b0 || req_done !== 4'b0000) begin failures++; $display("FAIL rstmid_ctl got=%b,%b,%b,%b exp=0000,0,0,0000", grant, busy, unit_start, req_done); end
        checks++; if (unit_a !== 32'd0 || unit_b !== 32'd0 || unit_op !== 1'b0 || result !== 32'd0) begin failures++; $display("FAIL rstmid_data got=%0d,%0d,%b,%0d exp=0,0,0,0", unit_a, unit_b, unit_op, result); end
        rst = 1'b1; req = 4'b0000;
        unit_done = 1'b1; unit_result = 32'd66;
        tick();
        unit_done = 1'b0;
        checks++; if (busy !== 1'b0 || req_done !== 4'b0000 || result !== 32'd0) begin failures++; $display("FAIL rstmid_late got=%b,%b,%0d exp=0,0000,0", busy, req_done, result); end
        // ptr was 1 before reset; from 0 requester 0 must win over requester 3
        req_a[0 +: W] = 32'd8;
        req = 4'b1001;
        tick();
        checks++; if (grant !== 4'b0001 || unit_a !== 32'd8) begin failures++; $display("FAIL rstmid_ptr got=%b,%0d exp=0001,8", grant, unit_a); end
        req = 4'b0000;
        tick();
        unit_done = 1'b1; unit_result = 32'd5;
        tick();
        unit_done = 1'b0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        req_a[1*W +: W] = 32'd1; req_b[1*W +: W] = 32'd2; req_op[1] = 1'b0;
        req = 4'b0010;
        tick(); // ISSUE
        for (int c = 1; c <= 10; c++) begin
            tick(); // WAIT cycle c
            checks++; if (req_done !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL tmo_wait cycle=%0d got=%b,%b exp=0000,1", c, req_done, busy); end
        end
        tick(); // RESP
        req = 4'b0000;
        checks++; if (req_done !== 4'b0010 || req_error !== 1'b1 || result !== 32'd0) begin failures++; $display("FAIL tmo_resp got=%b,%b,%0d exp=0010,1,0", req_done, req_error, result); end
        tick();
        checks++; if (req_error !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL tmo_after got=%b,%b exp=0,0", req_error, busy); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_drop();
        test_spurious_done();
        test_reset_mid_op();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
